// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the memory block-copy initiator.
// Provides the FSM state encoding, the word stride and the system memory map.
package mem_copy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned WORD_BYTES = 4;

  localparam logic [31:0] ROM_BASE = 32'h0040_0000;
  localparam logic [31:0] RAM_BASE = 32'h1001_0000;

endpackage

// File: rtl/mem_copy_initiator.sv
// Word-at-a-time memory copier: READ then WRITE per word, done_o 2N+1 cycles after start; start ignored while busy.
// MEM_COPY_CHECKSUM_EN adds checksum_o, the modular sum of every word written.
module mem_copy_initiator #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [DATA_WIDTH-1:0] Read_Data_i,
  output logic [ADDR_WIDTH-1:0] Address_o,
  output logic [DATA_WIDTH-1:0] write_data_o,
  output logic                  write_enable_o,
  output logic                  busy_o,
  output logic                  done_o,
`ifdef MEM_COPY_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] checksum_o,
`endif
  output logic [LEN_WIDTH-1:0]  words_copied_o
);
  import mem_copy_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(WORD_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(WORD_BYTES - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif

  always_comb begin
    state_d        = state_q;
    src_d          = src_q;
    dst_d          = dst_q;
    rem_d          = rem_q;
    cnt_d          = cnt_q;
    data_d         = data_q;
`ifdef MEM_COPY_CHECKSUM_EN
    sum_d          = sum_q;
`endif
    Address_o      = '0;
    write_enable_o = 1'b0;
    busy_o         = 1'b0;
    done_o         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d   = src_addr_i & ALIGN_MASK;
          dst_d   = dst_addr_i & ALIGN_MASK;
          rem_d   = len_i;
          cnt_d   = '0;
`ifdef MEM_COPY_CHECKSUM_EN
          sum_d   = '0;
`endif
          state_d = (len_i == '0) ? DONE : READ;
        end
      end
      READ: begin
        busy_o    = 1'b1;
        Address_o = src_q;
        data_d    = Read_Data_i;
        src_d     = src_q + STEP;
        state_d   = WRITE;
      end
      WRITE: begin
        busy_o         = 1'b1;
        Address_o      = dst_q;
        write_enable_o = 1'b1;
        dst_d          = dst_q + STEP;
        cnt_d          = cnt_q + LEN_WIDTH'(1);
        rem_d          = rem_q - LEN_WIDTH'(1);
`ifdef MEM_COPY_CHECKSUM_EN
        sum_d          = sum_q + data_q;
`endif
        // rem_q is the count before this write, so 1 means this was the last word
        state_d        = (rem_q == LEN_WIDTH'(1)) ? DONE : READ;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef MEM_COPY_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // The read latch doubles as the write-data register, so it holds between writes
  assign write_data_o   = data_q;
  assign words_copied_o = cnt_q;
`ifdef MEM_COPY_CHECKSUM_EN
  assign checksum_o     = sum_q;
`endif

endmodule

// File: tb/tb_mem_copy_initiator.sv
// Bench for mem_copy_initiator: behavioural ROM/RAM model plus a write scoreboard.
module tb_mem_copy_initiator;
  import mem_copy_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [31:0] src_addr_i;
  logic [31:0] dst_addr_i;
  logic [15:0] len_i;
  logic [31:0] Read_Data_i;
  logic [31:0] Address_o;
  logic [31:0] write_data_o;
  logic        write_enable_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] words_copied_o;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0] checksum_o;
`endif

  always #5 clk_i = ~clk_i;

  mem_copy_initiator dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .src_addr_i     (src_addr_i),
    .dst_addr_i     (dst_addr_i),
    .len_i          (len_i),
    .Read_Data_i    (Read_Data_i),
    .Address_o      (Address_o),
    .write_data_o   (write_data_o),
    .write_enable_o (write_enable_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
`ifdef MEM_COPY_CHECKSUM_EN
    .checksum_o     (checksum_o),
`endif
    .words_copied_o (words_copied_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic [31:0] rom [0:63];
  logic [31:0] ram [0:63];
  wr_t         exp_q[$];
  wr_t         mon_e;
  int          checks = 0;
  int          errors = 0;

  always_comb begin
    Read_Data_i = 32'hBAD0_BAD0;
    if (Address_o[31:8] == ROM_BASE[31:8])      Read_Data_i = rom[Address_o[7:2]];
    else if (Address_o[31:8] == RAM_BASE[31:8]) Read_Data_i = ram[Address_o[7:2]];
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a[31:8] == ROM_BASE[31:8]) return rom[a[7:2]];
    if (a[31:8] == RAM_BASE[31:8]) return ram[a[7:2]];
    return 32'hBAD0_BAD0;
  endfunction

  // Memory write port and scoreboard: every strobe must match the next expected write
  always @(negedge clk_i) begin
    if (write_enable_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h expected no write", Address_o, write_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (Address_o !== mon_e.addr || write_data_o !== mon_e.data) begin
          errors++;
          $display("FAIL write_order got addr=%h data=%h expected addr=%h data=%h",
                   Address_o, write_data_o, mon_e.addr, mon_e.data);
        end
      end
      if (Address_o[31:8] == RAM_BASE[31:8]) ram[Address_o[7:2]] <= write_data_o;
    end
  end

  task automatic fill_ram();
    for (int i = 0; i < 64; i++) ram[i] <= 32'hDEAD_0000 + 32'(i);
    @(negedge clk_i);
  endtask

  // Call right after a negedge; returns at the negedge of cycle 1 after the start edge.
  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    logic [31:0] sa, da;
    wr_t e;
    sa = s & 32'hFFFF_FFFC;
    da = d & 32'hFFFF_FFFC;
    for (int i = 0; i < int'(n); i++) begin
      e.addr = da + 32'(4 * i);
      e.data = mem_rd(sa + 32'(4 * i));
      exp_q.push_back(e);
    end
    src_addr_i = s;
    dst_addr_i = d;
    len_i      = n;
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i    = 1'b0;
  endtask

  task automatic wait_done(input int n, input bit spam, output int cyc, output int we_cnt);
    cyc    = 1;
    we_cnt = 0;
    while (done_o !== 1'b1 && cyc < 2 * n + 20) begin
      if (write_enable_o === 1'b1) we_cnt++;
      if (spam && cyc >= 2) begin
        start_i    = 1'b1;
        src_addr_i = 32'h0040_0080;
        dst_addr_i = 32'h1001_00C0;
        len_i      = 16'd3;
      end
      @(negedge clk_i);
      cyc++;
    end
  endtask

  task automatic check_done(input string name, input int n, input int cyc, input int we_cnt);
    checks++;
    if (done_o !== 1'b1 || cyc != 2 * n + 1) begin
      errors++;
      $display("FAIL %s_done_timing got cycle=%0d done=%b expected cycle=%0d done=1", name, cyc, done_o, 2 * n + 1);
    end
    checks++;
    if (we_cnt != n) begin
      errors++;
      $display("FAIL %s_write_cycles got %0d expected %0d", name, we_cnt, n);
    end
    checks++;
    if (busy_o !== 1'b0 || words_copied_o !== 16'(n)) begin
      errors++;
      $display("FAIL %s_done_state got busy=%b words=%0d expected busy=0 words=%0d", name, busy_o, words_copied_o, n);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes got %0d pending expected 0", name, exp_q.size());
    end
  endtask

  task automatic check_ram(input string name, input int idx, input logic [31:0] exp);
    checks++;
    if (ram[idx] !== exp) begin
      errors++;
      $display("FAIL %s_ram[%0d] got %h expected %h", name, idx, ram[idx], exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (Address_o !== 32'h0 || write_data_o !== 32'h0 || write_enable_o !== 1'b0 ||
        busy_o !== 1'b0 || done_o !== 1'b0 || words_copied_o !== 16'h0) begin
      errors++;
      $display("FAIL %s_outputs got addr=%h wdata=%h we=%b busy=%b done=%b words=%0d expected all zero",
               name, Address_o, write_data_o, write_enable_o, busy_o, done_o, words_copied_o);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    start_i = 1'b1;
    src_addr_i = ROM_BASE;
    dst_addr_i = RAM_BASE;
    len_i = 16'd4;
    repeat (3) @(negedge clk_i);
    check_idle_outputs("reset");
    reset_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk_i);
    check_idle_outputs("reset_wins_over_start");
  endtask

  task automatic test_basic_copy();
    int cyc, wec;
    fill_ram();
    do_start(ROM_BASE, RAM_BASE, 16'd8);
    checks++;
    if (busy_o !== 1'b1 || Address_o !== ROM_BASE || write_enable_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_first_read got busy=%b addr=%h we=%b expected busy=1 addr=%h we=0",
               busy_o, Address_o, write_enable_o, ROM_BASE);
    end
    wait_done(8, 1'b0, cyc, wec);
    check_done("basic", 8, cyc, wec);
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse got done=%b expected 0", done_o);
    end
    for (int i = 0; i < 8; i++) check_ram("basic", i, 32'(i));
    check_ram("basic_untouched", 8, 32'hDEAD_0008);
  endtask

  task automatic test_zero_len();
    do_start(ROM_BASE, RAM_BASE + 32'h100, 16'd0);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || write_enable_o !== 1'b0 || words_copied_o !== 16'd0) begin
      errors++;
      $display("FAIL zero_len got done=%b busy=%b we=%b words=%0d expected done=1 busy=0 we=0 words=0",
               done_o, busy_o, write_enable_o, words_copied_o);
    end
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_after got done=%b busy=%b expected 0 0", done_o, busy_o);
    end
  endtask

  task automatic test_unaligned();
    int cyc, wec;
    do_start(32'h0040_0006, 32'h1001_0003, 16'd1);
    checks++;
    if (Address_o !== 32'h0040_0004) begin
      errors++;
      $display("FAIL unaligned_read_addr got %h expected 00400004", Address_o);
    end
    wait_done(1, 1'b0, cyc, wec);
    check_done("unaligned", 1, cyc, wec);
    check_ram("unaligned", 0, 32'h1);
  endtask

  task automatic test_reset_mid_copy();
    int cyc, wec;
    fill_ram();
    do_start(ROM_BASE, RAM_BASE, 16'd8);
    repeat (5) @(negedge clk_i);
    checks++;
    if (write_enable_o !== 1'b1 || Address_o !== RAM_BASE + 32'h8) begin
      errors++;
      $display("FAIL mid_third_write got we=%b addr=%h expected we=1 addr=%h", write_enable_o, Address_o, RAM_BASE + 32'h8);
    end
    reset_i = 1'b1;
    @(negedge clk_i);
    check_idle_outputs("mid_reset");
    reset_i = 1'b0;
    checks++;
    if (exp_q.size() != 5) begin
      errors++;
      $display("FAIL mid_reset_pending got %0d expected 5", exp_q.size());
    end
    exp_q.delete();
    for (int i = 0; i < 3; i++) check_ram("mid_written", i, 32'(i));
    for (int i = 3; i < 8; i++) check_ram("mid_unchanged", i, 32'hDEAD_0000 + 32'(i));
    do_start(ROM_BASE + 32'h20, RAM_BASE + 32'h40, 16'd4);
    wait_done(4, 1'b0, cyc, wec);
    check_done("after_reset", 4, cyc, wec);
    for (int i = 0; i < 4; i++) check_ram("after_reset", 16 + i, 32'h108 + 32'(i));
  endtask

  task automatic test_start_while_busy();
    int cyc, wec;
    @(negedge clk_i);
    do_start(ROM_BASE + 32'h30, RAM_BASE + 32'h80, 16'd4);
    wait_done(4, 1'b1, cyc, wec);
    check_done("busy_start", 4, cyc, wec);
    // start_i is still high through DONE, which must also ignore it
    @(negedge clk_i);
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_after_done got busy=%b done=%b expected 0 0", busy_o, done_o);
    end
    for (int i = 0; i < 4; i++) check_ram("busy_start", 32 + i, 32'h10C + 32'(i));
    check_ram("busy_start_other_dst", 48, 32'hDEAD_0030);
  endtask

`ifdef MEM_COPY_CHECKSUM_EN
  task automatic test_checksum();
    int cyc, wec;
    @(negedge clk_i);
    do_start(ROM_BASE + 32'h40, RAM_BASE + 32'h20, 16'd2);
    wait_done(2, 1'b0, cyc, wec);
    check_done("checksum", 2, cyc, wec);
    checks++;
    if (checksum_o !== 32'h0000_0001) begin
      errors++;
      $display("FAIL checksum got %h expected 00000001", checksum_o);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = (i < 8) ? 32'(i) : 32'h100 + 32'(i);
    rom[16] = 32'hFFFF_FFFF;
    rom[17] = 32'h0000_0002;
    reset_i    = 1'b1;
    start_i    = 1'b0;
    src_addr_i = '0;
    dst_addr_i = '0;
    len_i      = '0;
    test_reset();
    test_basic_copy();
    test_zero_len();
    test_unaligned();
    test_reset_mid_copy();
    test_start_while_busy();
`ifdef MEM_COPY_CHECKSUM_EN
    test_checksum();
`endif
    repeat (2) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
